debug_grid_render: RTL and testbench
====================================

# debug_grid_render

Parametrised successor to the fixed 1280x1024 binary debug display. It renders a grid of words read from a debug RAM as coloured bit cells. It adds configurable word width, column and row count, cell size and RAM read latency, a frame-latched scroll base address, and a highlighted cursor word. It sits between the sync generator and the VGA output registers, and drives the read port of the debug RAM.

## Interface

- DATA_W, 8: bits per RAM word and bit cells per field.
- COLS, 16: data words per text row; power of two.
- ROWS, 63: data text rows below the header row.
- ADDR_W, 10: RAM address width.
- CELL_LOG2, 3: cell is 2^CELL_LOG2 pixels square.
- RAM_LAT, 1: RAM read latency in cycles (1..3).
- X_W, 11: width of the pixel counters.

- clk, in, 1: pixel clock.
- rst, in, 1: synchronous, active-high reset.
- in_display, in, 1: display-area flag, aligned to the pixel being output.
- prefetch_x, in, X_W: horizontal counter running RAM_LAT+2 cycles ahead of the output pixel.
- counter_y, in, X_W: vertical counter.
- base_addr, in, ADDR_W: word shown at data row 0, column 0.
- cursor_addr, in, ADDR_W: word to highlight.
- cursor_en, in, 1: highlight enable.
- ram_addr, out, ADDR_W: registered RAM read address.
- ram_data, in, DATA_W: RAM data, valid RAM_LAT cycles after ram_addr.
- vga_r, vga_g, vga_b, out, 1 each: registered pixel outputs.

## Operation

- Cell coordinates: bx = prefetch_x >> CELL_LOG2, by = counter_y >> CELL_LOG2.
- Field layout: F = DATA_W+1 cells; field f = bx / F, cell position p = bx % F. Field 0 is the row label; fields 1..COLS are data words.
- Text layout: text row t = by >> 1, and cell rows with odd by are gaps. Text row 0 is the header; text row t ≥ 1 is data row t-1.
- Black pixel when any of these holds:
  - p == DATA_W (field border);
  - by is odd (gap row);
  - f > COLS or t > ROWS (out of range);
  - low CELL_LOG2 bits of prefetch_x or counter_y are 0 (grid line).
- Shown bit index is DATA_W-1-p, so the MSB is leftmost.
  - Label field: row index t-1, LSB-justified, zero-extended to DATA_W. The header row's label field is black.
  - Header data fields: column index f-1.
  - Data fields: ram_data.
- Colour: bit 1 gives 3'b110, bit 0 gives 3'b001. For a data cell whose word address equals the latched cursor with cursor enabled: bit 1 gives 3'b111, bit 0 gives 3'b100.
- Address generation: addr = (base_l + (t-1)*COLS + (f-1)) mod 2^ADDR_W.
  - Implemented with a row_base register, no multiplier.
  - row_base loads base_l on entering text row 1 and adds COLS on each later text-row change.
  - Column offset comes from a field counter stepped at field boundaries.
  - Wraps at 2^ADDR_W.
- Frame latch: base_addr, cursor_addr and cursor_en are sampled into base_l, cursor_l and cen_l only when counter_y==0 and prefetch_x==0. Mid-frame changes take effect next frame, so scrolling does not tear.
- armed flag: cleared by rst, set at the first frame latch. While not armed, outputs are forced black.

## Timing

- Pipeline stages:
  - Stage 0: decode prefetch_x and counter_y, register ram_addr.
  - RAM_LAT cycles of RAM read latency, with decode results delayed alongside.
  - Compose stage: colour is registered into a one-cycle delay.
  - Output stage: AND with in_display.
- Pixel for prefetch_x = X appears on the vga_* outputs exactly RAM_LAT+2 cycles after X is presented.
- in_display is applied at the output register only and is not delayed.
- Reset values: vga_r/g/b = 0, ram_addr = 0, all pipeline stages = 0, base_l = cursor_l = 0, cen_l = 0, armed = 0.
- Reset mid-frame: outputs go to 0 on the next clock and stay black until the next frame latch. No stale pipeline data may reach the outputs.
- Frame latch coinciding with rst: rst wins; armed stays 0 until the following frame.
- cursor_l equals an address that is not displayed: no highlight, no side effects.

## Test plan

- Defaults, base=0, ram[0]=0x80, pixel (x=76, y=20) → vga=110 after RAM_LAT+2 cycles; (x=132, y=20) → 001; (x=140, y=20) border → 000; (x=72, y=20) grid → 000.
- Header and label: (x=140+8*… field 4, bit 0 cell, y=4) shows column index 3 bit 0 → 110. Data row 5 label bit 0 → 110, bit 1 → 001.
- Wrap: base=0x3F8, data row 0 field 10 reads ram_addr=0x001. Data row 1 field 1 reads 0x008.
- Cursor: cursor_addr=0x011, cursor_en=1, ram[0x11]=0x0F → data row 1 field 2 bits 7..4 = 100, bits 3..0 = 111. Other words keep 110/001.
- Tear-free: change base_addr mid-frame → ram_addr sequence is unchanged until the next counter_y==0, prefetch_x==0.
- Reset mid-frame: assert rst for 1 cycle at y=500 → vga=000 from the next cycle until one cycle after the next frame's first displayed pixel. Also sweep RAM_LAT=2 and 3 and confirm output alignment.

Source files
------------

// File: rtl/debug_grid_render_if.sv
// Bus between the debug grid renderer and its surroundings: sync counters,
// frame controls, debug-RAM read port and pixel outputs.
interface debug_grid_render_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int X_W    = 11
);
   logic              in_display;
   logic [X_W-1:0]    prefetch_x;
   logic [X_W-1:0]    counter_y;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] cursor_addr;
   logic              cursor_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              vga_r;
   logic              vga_g;
   logic              vga_b;

   modport master (
      output in_display, prefetch_x, counter_y, base_addr, cursor_addr, cursor_en, ram_data,
      input  ram_addr, vga_r, vga_g, vga_b
   );

   modport slave (
      input  in_display, prefetch_x, counter_y, base_addr, cursor_addr, cursor_en, ram_data,
      output ram_addr, vga_r, vga_g, vga_b
   );
endinterface

// File: rtl/debug_grid_render.sv
// Renders debug-RAM words as a grid of coloured bit cells with a row-label
// column, a column-index header row, frame-latched scroll base and cursor.
module debug_grid_render #(
   parameter int DATA_W    = 8,
   parameter int COLS      = 16,
   parameter int ROWS      = 63,
   parameter int ADDR_W    = 10,
   parameter int CELL_LOG2 = 3,
   parameter int RAM_LAT   = 1,
   parameter int X_W       = 11
) (
   input  logic                clk,
   input  logic                rst,
   debug_grid_render_if.slave  bus
);
   localparam int F_W = $clog2(COLS + 2);
   localparam int P_W = $clog2(DATA_W + 1);
   localparam int B_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int T_W = X_W - CELL_LOG2 - 1;

   typedef struct packed {
      logic           vis;
      logic           dat;
      logic           fbit;
      logic           hl;
      logic [B_W-1:0] idx;
   } dec_t;

   logic [ADDR_W-1:0] base_l_q, cursor_l_q, row_base_q, row_base_d, ram_addr_q, addr_d;
   logic              cen_l_q, armed_q, latch;
   logic [F_W-1:0]    fld_q, fld_d;
   logic [P_W-1:0]    pos_q, pos_d, ridx;
   logic [T_W-1:0]    trow_q, trow;
   logic [B_W-1:0]    idx_d;
   logic [DATA_W-1:0] lab_v, col_v;
   dec_t              dec_d, dec_last;
   dec_t [RAM_LAT:0]  dec_q;
   logic [2:0]        col_q, col_d, vga_q;
   logic              dat_bit;

   // Stage 0: decode cell position; field/cell counters assume x steps by one from 0.
   always_comb begin
      latch = (bus.counter_y == '0) && (bus.prefetch_x == '0);
      trow  = bus.counter_y[X_W-1:CELL_LOG2+1];
      fld_d = fld_q;
      pos_d = pos_q;
      if (bus.prefetch_x == '0) begin
         fld_d = '0;
         pos_d = '0;
      end else if (bus.prefetch_x[CELL_LOG2-1:0] == '0) begin
         if (pos_q == P_W'(DATA_W)) begin
            pos_d = '0;
            if (fld_q <= F_W'(COLS)) fld_d = fld_q + F_W'(1);
         end else begin
            pos_d = pos_q + P_W'(1);
         end
      end

      row_base_d = row_base_q;
      if (trow != trow_q)
         row_base_d = (trow == T_W'(1)) ? base_l_q : row_base_q + ADDR_W'(COLS);
      addr_d = row_base_d + ADDR_W'(fld_d) - ADDR_W'(1);

      ridx  = P_W'(DATA_W - 1) - pos_d;
      idx_d = B_W'(ridx);
      lab_v = DATA_W'(trow - T_W'(1));
      col_v = DATA_W'(fld_d - F_W'(1));

      dec_d      = '0;
      dec_d.idx  = idx_d;
      dec_d.dat  = (fld_d != '0) && (trow != '0);
      dec_d.fbit = (fld_d == '0) ? lab_v[idx_d] : col_v[idx_d];
      dec_d.hl   = dec_d.dat && cen_l_q && (addr_d == cursor_l_q);
      dec_d.vis  = (armed_q || latch)
                && (pos_d != P_W'(DATA_W))
                && !bus.counter_y[CELL_LOG2]
                && (fld_d <= F_W'(COLS))
                && (trow <= T_W'(ROWS))
                && (|bus.prefetch_x[CELL_LOG2-1:0])
                && (|bus.counter_y[CELL_LOG2-1:0])
                && !((trow == '0) && (fld_d == '0));
   end

   assign dec_last = dec_q[RAM_LAT];

   // Compose: decode info has travelled alongside the RAM read and meets its data here.
   always_comb begin
      dat_bit = dec_last.dat ? bus.ram_data[dec_last.idx] : dec_last.fbit;
      col_d   = 3'b000;
      if (dec_last.vis) begin
         if (dec_last.hl) col_d = dat_bit ? 3'b111 : 3'b100;
         else             col_d = dat_bit ? 3'b110 : 3'b001;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_l_q   <= '0;
         cursor_l_q <= '0;
         cen_l_q    <= 1'b0;
         armed_q    <= 1'b0;
         fld_q      <= '0;
         pos_q      <= '0;
         trow_q     <= '0;
         row_base_q <= '0;
         ram_addr_q <= '0;
         dec_q      <= '0;
         col_q      <= '0;
         vga_q      <= '0;
      end else begin
         if (latch) begin
            base_l_q   <= bus.base_addr;
            cursor_l_q <= bus.cursor_addr;
            cen_l_q    <= bus.cursor_en;
            armed_q    <= 1'b1;
         end
         fld_q      <= fld_d;
         pos_q      <= pos_d;
         trow_q     <= trow;
         row_base_q <= row_base_d;
         ram_addr_q <= addr_d;
         dec_q      <= {dec_q[RAM_LAT-1:0], dec_d};
         col_q      <= col_d;
         vga_q      <= col_q & {3{bus.in_display}};
      end
   end

   assign bus.ram_addr = ram_addr_q;
   assign bus.vga_r    = vga_q[2];
   assign bus.vga_g    = vga_q[1];
   assign bus.vga_b    = vga_q[0];
endmodule

// File: tb/tb_debug_grid_render.sv
// Bench for debug_grid_render: three instances (RAM_LAT 1..3) share one stimulus
// and are checked every cycle against a coordinate-level reference model.
module tb_debug_grid_render;
   localparam int DATA_W = 8, COLS = 16, ROWS = 63, ADDR_W = 10, CELL_LOG2 = 3, X_W = 11;
   localparam int F = DATA_W + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, ind, cen;
   logic [X_W-1:0]    px, cy;
   logic [ADDR_W-1:0] base_a, cur_a;
   logic [DATA_W-1:0] mem [1024];
   logic [2:0]        vga_w   [3];
   logic [ADDR_W-1:0] raddr_w [3];

   for (genvar g = 0; g < 3; g++) begin : g_lane
      localparam int RL = g + 1;
      debug_grid_render_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .X_W(X_W)) bus ();
      logic [DATA_W-1:0] rp [RL];
      assign bus.in_display  = ind;
      assign bus.prefetch_x  = px;
      assign bus.counter_y   = cy;
      assign bus.base_addr   = base_a;
      assign bus.cursor_addr = cur_a;
      assign bus.cursor_en   = cen;
      assign bus.ram_data    = rp[RL-1];
      always @(posedge clk) begin
         rp[0] <= mem[bus.ram_addr];
         for (int i = 1; i < RL; i++) rp[i] <= rp[i-1];
      end
      debug_grid_render #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W),
                          .CELL_LOG2(CELL_LOG2), .RAM_LAT(RL), .X_W(X_W))
         dut (.clk(clk), .rst(rst), .bus(bus.slave));
      assign vga_w[g]   = {bus.vga_r, bus.vga_g, bus.vga_b};
      assign raddr_w[g] = bus.ram_addr;
   end

   int errors = 0, checks = 0, k = 0, last_rst = 0;
   logic              armed_m = 1'b0, cen_m = 1'b0;
   logic [ADDR_W-1:0] base_m = '0, cur_m = '0;
   logic [2:0]        hcol [64];
   int                hx   [64];
   logic [2:0]        pix_obs [3][2048];
   logic [ADDR_W-1:0] ram_obs [3][2048];

   // Pixel colour straight from the display rules, using plain division and multiplication.
   function automatic void model(input int x, input int y, output logic [2:0] col,
                                 output logic isdat, output logic [ADDR_W-1:0] addr);
      int bx, by, f, p, t, b, bitv;
      logic hl;
      bx = x >> CELL_LOG2; by = y >> CELL_LOG2;
      f = bx / F; p = bx % F; t = by >> 1; b = DATA_W - 1 - p;
      col = 3'b000; isdat = 1'b0; addr = '0; hl = 1'b0; bitv = 0;
      if (f >= 1 && f <= COLS && t >= 1 && t <= ROWS) begin
         isdat = armed_m;
         addr  = ADDR_W'((int'(base_m) + (t - 1) * COLS + f - 1) % 1024);
      end
      if (armed_m && p != DATA_W && by % 2 == 0 && f <= COLS && t <= ROWS &&
          x % 8 != 0 && y % 8 != 0 && !(t == 0 && f == 0)) begin
         if (f == 0)      bitv = ((t - 1) >> b) & 1;
         else if (t == 0) bitv = ((f - 1) >> b) & 1;
         else begin
            bitv = int'(mem[addr][b]);
            hl   = cen_m && (addr == cur_m);
         end
         if (hl) col = (bitv != 0) ? 3'b111 : 3'b100;
         else    col = (bitv != 0) ? 3'b110 : 3'b001;
      end
   endfunction

   task automatic step(input int x, input int y, input logic r);
      logic [2:0] c, want;
      logic d;
      logic [ADDR_W-1:0] a;
      int j, xj;
      px = X_W'(x); cy = X_W'(y); rst = r;
      @(posedge clk);
      k++;
      if (r) begin
         last_rst = k; armed_m = 1'b0;
      end else if (x == 0 && y == 0) begin
         base_m = base_a; cur_m = cur_a; cen_m = cen; armed_m = 1'b1;
      end
      model(x, y, c, d, a);
      if (r) begin c = 3'b000; d = 1'b0; end
      hcol[k % 64] = c; hx[k % 64] = x;
      #1;
      for (int g = 0; g < 3; g++) begin
         j    = k - g - 3;
         xj   = (j >= 1) ? hx[j % 64] : -1;
         want = (j > last_rst) ? (hcol[j % 64] & {3{ind}}) : 3'b000;
         checks++;
         assert (vga_w[g] === want) else begin
            errors++;
            $error("FAIL vga lat=%0d x=%0d y=%0d got=%b exp=%b", g + 1, xj, y, vga_w[g], want);
         end
         if (j >= 1) pix_obs[g][xj] = vga_w[g];
         ram_obs[g][x] = raddr_w[g];
         if (d) begin
            checks++;
            assert (raddr_w[g] === a) else begin
               errors++;
               $error("FAIL ram_addr lat=%0d x=%0d y=%0d got=%h exp=%h", g + 1, x, y, raddr_w[g], a);
            end
         end
      end
   endtask

   task automatic line(input int y, input int xmax, input bit rnd);
      for (int x = 0; x <= xmax + 6; x++) begin
         ind = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
         step(x, y, 1'b0);
      end
   endtask

   task automatic chk_pix(input string tag, input int x, input logic [2:0] want);
      for (int g = 0; g < 3; g++) begin
         checks++;
         assert (pix_obs[g][x] === want) else begin
            errors++;
            $error("FAIL %s lat=%0d got=%b exp=%b", tag, g + 1, pix_obs[g][x], want);
         end
      end
   endtask

   task automatic chk_ram(input string tag, input int x, input logic [ADDR_W-1:0] want);
      for (int g = 0; g < 3; g++) begin
         checks++;
         assert (ram_obs[g][x] === want) else begin
            errors++;
            $error("FAIL %s lat=%0d got=%h exp=%h", tag, g + 1, ram_obs[g][x], want);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
      mem[0] = 8'h80; mem[16] = 8'h80; mem[17] = 8'h0F;
      base_a = '0; cur_a = '0; cen = 1'b0; ind = 1'b1; px = '0; cy = '0; rst = 1'b1;

      repeat (4) step(3, 5, 1'b1);
      for (int g = 0; g < 3; g++) begin
         checks++;
         assert (raddr_w[g] === 10'h000) else begin
            errors++;
            $error("FAIL reset_ram_addr lat=%0d got=%h exp=000", g + 1, raddr_w[g]);
         end
      end
      line(20, 200, 1'b0);
      chk_pix("unarmed", 76, 3'b000);

      // Frame A: defaults, header row and labels
      line(0, 40, 1'b0);
      line(4, 360, 1'b0);
      chk_pix("hdr_f4_b0", 348, 3'b110);
      chk_pix("hdr_f4_b1", 340, 3'b110);
      chk_pix("hdr_f4_b2", 332, 3'b001);
      chk_pix("hdr_label", 60, 3'b000);
      line(20, 200, 1'b0);
      chk_pix("data_msb", 76, 3'b110);
      chk_pix("data_lsb", 132, 3'b001);
      chk_pix("border", 140, 3'b000);
      chk_pix("grid", 72, 3'b000);
      chk_ram("addr_r0_f1", 76, 10'h000);
      for (int t = 2; t <= 5; t++) line(16 * t + 4, 80, 1'b0);
      line(100, 80, 1'b0);
      chk_pix("label5_b0", 60, 3'b110);
      chk_pix("label5_b1", 52, 3'b001);

      // Frame B: cursor on word 0x011
      cur_a = 10'h011; cen = 1'b1;
      line(0, 40, 1'b0);
      line(4, 40, 1'b0);
      line(20, 200, 1'b0);
      line(36, 200, 1'b0);
      chk_pix("cur_b7", 148, 3'b100);
      chk_pix("cur_b4", 172, 3'b100);
      chk_pix("cur_b3", 180, 3'b111);
      chk_pix("noncur", 76, 3'b110);

      // Frame C: address wrap, then a mid-frame base change
      base_a = 10'h3F8; cen = 1'b0;
      line(0, 40, 1'b0);
      line(4, 40, 1'b0);
      line(20, 760, 1'b0);
      chk_ram("wrap_r0_f1", 76, 10'h3F8);
      chk_ram("wrap_r0_f10", 724, 10'h001);
      base_a = 10'h123;
      line(36, 200, 1'b0);
      chk_ram("tearfree_r1_f1", 76, 10'h008);
      line(0, 40, 1'b0);
      line(4, 40, 1'b0);
      line(20, 100, 1'b0);
      chk_ram("newbase_r0_f1", 76, 10'h123);

      // Reset for one cycle in the middle of line y=500
      base_a = '0;
      for (int t = 2; t <= 30; t++) line(16 * t + 4, 30, 1'b1);
      for (int x = 0; x <= 206; x++) begin
         ind = 1'b1;
         step(x, 500, x == 100);
      end
      chk_pix("after_rst", 150, 3'b000);
      line(516, 200, 1'b0);
      chk_pix("rst_unarmed", 76, 3'b000);
      line(0, 40, 1'b0);
      line(4, 40, 1'b0);
      line(20, 200, 1'b0);
      chk_pix("rst_recover", 76, 3'b110);

      // Random frames with random base, cursor and display gating
      repeat (2) begin
         base_a = ADDR_W'($urandom);
         cur_a  = base_a + ADDR_W'($urandom_range(0, 40));
         cen    = 1'($urandom_range(0, 1));
         line(0, 40, 1'b1);
         for (int t = 0; t < 8; t++) begin
            if (t == 3) base_a = ADDR_W'($urandom);
            line(16 * t + int'($urandom_range(0, 15)), 1240, 1'b1);
         end
      end

      // Tall frame: every text row including those past the last data row
      base_a = ADDR_W'($urandom);
      cur_a  = base_a + ADDR_W'(COLS);
      cen    = 1'b1;
      line(0, 40, 1'b1);
      for (int t = 0; t <= ROWS + 2; t++) line(16 * t + int'($urandom_range(0, 15)), 100, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
